// File: rtl/iq_pkg.sv
// Shared types for the ALU dispatch/issue-queue slice.
//   IQ_NUM_MAX    : largest supported number of ALU issue queues
//   credit_t      : credit counter type for the default IQ depth
//   iq_choose_t   : per-IQ slot select, bit k selects dispatch slot k
//   decode_info_t : decoded instruction info carried to the IQs
//   data_t        : operand data carried to the IQs
package iq_pkg;
  localparam int IQ_NUM_MAX  = 4;
  localparam int IQ_SIZE_DEF = 4;

  typedef logic [$clog2(IQ_SIZE_DEF+1)-1:0] credit_t;
  typedef logic [1:0] iq_choose_t;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [3:0] alu_op;
    logic [3:0] imm_sel;
    logic       rd_en;
    logic       use_imm;
  } decode_info_t;

  typedef logic [31:0] data_t;
endpackage

// File: rtl/iq_credit_counter.sv
// Free-entry credit counter for one ALU issue queue.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : refill to IQ_SIZE, error flag held
//   dec_i      : an instruction was dispatched into this IQ
//   inc_i      : the IQ issued (freed) an entry
//   credit_o   : current free-entry count
//   err_o      : sticky overflow/underflow flag
module iq_credit_counter #(
  parameter int IQ_SIZE = 4,
  parameter int CW      = $clog2(IQ_SIZE+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          dec_i,
  input  logic          inc_i,
  output logic [CW-1:0] credit_o,
  output logic          err_o
);
  localparam logic [CW-1:0] FULL = CW'(IQ_SIZE);

  logic [CW-1:0] credit_q;
  logic          err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q <= FULL;
      err_q    <= 1'b0;
    end else if (flush) begin
      credit_q <= FULL;
    end else begin
      unique case ({dec_i, inc_i})
        2'b10: begin
          // Underflow cannot happen while the picker only uses nonzero credits.
          if (credit_q == '0) err_q <= 1'b1;
          else                credit_q <= credit_q - 1'b1;
        end
        2'b01: begin
          // An issue pulse on a full IQ is a bookkeeping error; saturate.
          if (credit_q == FULL) err_q <= 1'b1;
          else                  credit_q <= credit_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign credit_o = credit_q;
  assign err_o    = err_q;

  a_no_underflow: assert property (@(posedge clk) disable iff (rst || flush)
    !(dec_i && !inc_i && credit_q == '0));
endmodule

// File: rtl/alu_dispatch_arb.sv
// Steers up to two in-order rename slots into distinct ALU issue queues.
//   clk, rst       : clock, synchronous active-high reset
//   flush          : refill credits, reset round-robin, block dispatch
//   disp_valid_i   : slot valid (slot 1 only with slot 0)
//   disp_di_i/data : per-slot payload, broadcast on p_di_c/p_data_c
//   disp_ready_o   : slot accepted this cycle (== p_valid_c)
//   iq_choose_o    : per IQ, bit k set when slot k is steered there
//   iq_issue_i     : per IQ entry-freed pulse (credit return)
//   stall_cnt_o    : cycles with slot 0 valid but not accepted
//   credit_err_o   : sticky credit overflow/underflow flag
module alu_dispatch_arb
  import iq_pkg::*;
#(
  parameter int IQ_NUM  = 2,
  parameter int IQ_SIZE = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [1:0]               disp_valid_i,
  input  decode_info_t [1:0]       disp_di_i,
  input  data_t [1:0]              disp_data_i,
  output logic [1:0]               disp_ready_o,
  output iq_choose_t [IQ_NUM-1:0]  iq_choose_o,
  output decode_info_t [1:0]       p_di_c,
  output data_t [1:0]              p_data_c,
  output logic [1:0]               p_valid_c,
  input  logic [IQ_NUM-1:0]        iq_issue_i,
  output logic [31:0]              stall_cnt_o,
  output logic                     credit_err_o
);
  localparam int CW  = $clog2(IQ_SIZE+1);
  localparam int RRW = $clog2(IQ_NUM);

  logic [IQ_NUM-1:0][CW-1:0] credit;
  logic [IQ_NUM-1:0]         elig, err, disp;
  logic [RRW-1:0]            rr_q, pick0, pick1;
  logic [CW-1:0]             best0, best1;
  logic                      found0, found1, acc0, acc1, block;
  logic [31:0]               stall_q;

  assign block = rst | flush;

  // Per-IQ credit counters.
  for (genvar i = 0; i < IQ_NUM; i++) begin : g_cred
    assign elig[i] = credit[i] != '0;
    assign disp[i] = |iq_choose_o[i];
    iq_credit_counter #(.IQ_SIZE(IQ_SIZE), .CW(CW)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .dec_i   (disp[i]),
      .inc_i   (iq_issue_i[i]),
      .credit_o(credit[i]),
      .err_o   (err[i])
    );
  end

  // Scan in round-robin order from rr_q; a strictly larger credit replaces
  // the current pick, so equal credits keep the earliest index in rr order.
  always_comb begin
    found0 = 1'b0; pick0 = '0; best0 = '0;
    found1 = 1'b0; pick1 = '0; best1 = '0;
    for (int j = 0; j < IQ_NUM; j++) begin
      int idx;
      logic [RRW-1:0] ix;
      idx = int'(rr_q) + j;
      if (idx >= IQ_NUM) idx = idx - IQ_NUM;
      ix = RRW'(idx);
      if (elig[ix] && (!found0 || credit[ix] > best0)) begin
        found0 = 1'b1; pick0 = ix; best0 = credit[ix];
      end
    end
    for (int j = 0; j < IQ_NUM; j++) begin
      int idx;
      logic [RRW-1:0] ix;
      idx = int'(rr_q) + j;
      if (idx >= IQ_NUM) idx = idx - IQ_NUM;
      ix = RRW'(idx);
      if (elig[ix] && ix != pick0 && (!found1 || credit[ix] > best1)) begin
        found1 = 1'b1; pick1 = ix; best1 = credit[ix];
      end
    end
  end

  assign acc0 = disp_valid_i[0] & found0 & ~block;
  assign acc1 = disp_valid_i[1] & acc0 & found1;

  always_comb begin
    iq_choose_o = '0;
    if (acc0) iq_choose_o[pick0][0] = 1'b1;
    if (acc1) iq_choose_o[pick1][1] = 1'b1;
  end

  assign disp_ready_o = {acc1, acc0};
  assign p_valid_c    = disp_ready_o;
  assign p_di_c       = disp_di_i;
  assign p_data_c     = disp_data_i;
  assign credit_err_o = |err;

  always_ff @(posedge clk) begin
    if (block) begin
      rr_q <= '0;
    end else if (acc0) begin
      rr_q <= (rr_q == RRW'(IQ_NUM-1)) ? '0 : rr_q + 1'b1;
    end
  end

  // Counter survives flush so stall statistics span pipeline flushes.
  always_ff @(posedge clk) begin
    if (rst)                                stall_q <= '0;
    else if (!flush && disp_valid_i[0] && !acc0) stall_q <= stall_q + 1'b1;
  end

  assign stall_cnt_o = stall_q;
endmodule
